rgbled_ctrl: RTL and testbench

- Sequencer directly upstream of ws281x_drv. It holds per-LED RGB colour registers and a global brightness register.
- On command, it snapshots all colours, applies brightness scaling, reorders each colour to GRB wire order, and streams one 24-bit word per LED through the driver's valid/ack/last handshake.
- It replaces the constant "all off" stimulus currently tied into the driver, making the RGB LED chain software-controllable.

---
 rtl/rgbled_pkg.sv | 23 ++
 rtl/rgbled_scale.sv | 12 +
 rtl/rgbled_ctrl.sv | 113 +++++++++++
 tb/tb_rgbled_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgbled_pkg.sv
// rgbled_pkg: shared types, reset constants and brightness scaling for the RGB LED sequencer
package rgbled_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef logic [23:0] grb_word_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} rgbled_state_e;

    localparam logic [7:0] BrightReset = 8'hFF;

    // bright+1 as multiplier makes 255 the identity; the product never exceeds 16 bits
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] bright);
        logic [15:0] p;
        p = {8'd0, c} * {7'd0, {1'b0, bright} + 9'd1};
        return 8'(p >> 8);
    endfunction

endpackage

// File: rtl/rgbled_scale.sv
// rgbled_scale: applies global brightness to one colour and reorders it to GRB wire order
module rgbled_scale
    import rgbled_pkg::*;
(
    input  rgb_t       i_col,
    input  logic [7:0] i_bright,
    output grb_word_t  o_word
);

    assign o_word = {scale8(i_col.g, i_bright), scale8(i_col.r, i_bright), scale8(i_col.b, i_bright)};

endmodule

// File: rtl/rgbled_ctrl.sv
// rgbled_ctrl: holds per-LED colours and brightness, snapshots them on command and streams GRB words to ws281x_drv
module rgbled_ctrl
    import rgbled_pkg::*;
#(
    parameter int NumLeds = 2,
    parameter int IdxW    = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            col_we_i,
    input  logic [IdxW-1:0] col_idx_i,
    input  logic [23:0]     col_i,
    input  logic            bright_we_i,
    input  logic [7:0]      bright_i,
    input  logic            update_i,
    input  logic            off_i,
    output logic            busy_o,
    output logic            go_o,
    output logic [23:0]     data_o,
    output logic            data_valid_o,
    output logic            data_last_o,
    input  logic            data_ack_i,
    input  logic            idle_i
);

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumLeds - 1);

    rgbled_state_e   r_state, w_state_nxt;
    rgb_t            r_col [NumLeds];
    grb_word_t       r_snap [NumLeds];
    grb_word_t       w_scaled [NumLeds];
    logic [7:0]      r_bright;
    logic            r_pend_upd, r_pend_off;
    logic [IdxW-1:0] r_idx;
    logic [IdxW-1:0] w_idx_nxt;
    grb_word_t       r_data;
    logic            r_valid;
    logic            w_upd, w_off, w_start, w_ack, w_at_last;

    // live command pulses count as pending so an IDLE start needs no extra cycle
    assign w_upd     = r_pend_upd | update_i;
    assign w_off     = r_pend_off | off_i;
    assign w_start   = (r_state == IDLE) & (w_upd | w_off);
    assign w_ack     = r_valid & data_ack_i;
    assign w_at_last = r_idx == LastIdx;
    assign w_idx_nxt = r_idx + 1'b1;

    for (genvar g = 0; g < NumLeds; g++) begin : g_scale
        rgbled_scale u_scale (
            .i_col    (r_col[g]),
            .i_bright (r_bright),
            .o_word   (w_scaled[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_start ? LOAD : IDLE;
            LOAD:    w_state_nxt = SEND;
            SEND:    w_state_nxt = (w_ack && w_at_last) ? LATCH : SEND;
            LATCH:   w_state_nxt = idle_i ? IDLE : LATCH;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumLeds; i++) begin
                r_col[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_bright   <= BrightReset;
            r_pend_upd <= 1'b0;
            r_pend_off <= 1'b0;
            r_idx      <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (col_we_i && 32'(col_idx_i) < NumLeds) r_col[col_idx_i] <= col_i;
            if (bright_we_i) r_bright <= bright_i;
            r_pend_upd <= w_start ? 1'b0 : w_upd;
            r_pend_off <= w_start ? 1'b0 : w_off;
            if (w_start) begin
                for (int i = 0; i < NumLeds; i++) r_snap[i] <= w_off ? '0 : w_scaled[i];
            end
            if (r_state == LOAD) begin
                r_idx   <= '0;
                r_data  <= r_snap[0];
                r_valid <= 1'b1;
            end else if (w_ack) begin
                if (w_at_last) begin
                    r_valid <= 1'b0;
                end else begin
                    r_idx  <= w_idx_nxt;
                    r_data <= r_snap[w_idx_nxt];
                end
            end
        end
    end

    assign busy_o       = (r_state != IDLE) | r_pend_upd | r_pend_off;
    assign go_o         = r_state != IDLE;
    assign data_o       = r_data;
    assign data_valid_o = r_valid;
    assign data_last_o  = r_valid & w_at_last;

endmodule

// File: tb/tb_rgbled_ctrl.sv
// tb_rgbled_ctrl: scoreboard bench with a ws281x driver model that stalls, acks and reports latch completion
module tb_rgbled_ctrl;

    localparam int N = 2;

    typedef struct {
        logic [23:0] d;
        logic        l;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        col_we_i;
    logic [0:0]  col_idx_i;
    logic [23:0] col_i;
    logic        bright_we_i;
    logic [7:0]  bright_i;
    logic        update_i;
    logic        off_i;
    logic        busy_o;
    logic        go_o;
    logic [23:0] data_o;
    logic        data_valid_o;
    logic        data_last_o;
    logic        data_ack_i;
    logic        idle_i;

    int          checks = 0;
    int          errors = 0;
    exp_t        q[$];
    logic [23:0] m_col [N];
    int          m_bright;
    int          stall_cfg;
    int          stall_left;
    int          latch_cnt;
    logic [23:0] held_d;
    logic        held_l;
    logic        held_v;

    rgbled_ctrl #(.NumLeds(N)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .col_we_i     (col_we_i),
        .col_idx_i    (col_idx_i),
        .col_i        (col_i),
        .bright_we_i  (bright_we_i),
        .bright_i     (bright_i),
        .update_i     (update_i),
        .off_i        (off_i),
        .busy_o       (busy_o),
        .go_o         (go_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o),
        .data_ack_i   (data_ack_i),
        .idle_i       (idle_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [23:0] exp_word(input logic [23:0] c, input int b);
        int r, g, bl;
        r  = (int'(c[23:16]) * (b + 1)) / 256;
        g  = (int'(c[15:8])  * (b + 1)) / 256;
        bl = (int'(c[7:0])   * (b + 1)) / 256;
        return {g[7:0], r[7:0], bl[7:0]};
    endfunction

    task automatic push_frame(input bit off);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            e.d = off ? 24'h0 : exp_word(m_col[i], m_bright);
            e.l = (i == N - 1);
            q.push_back(e);
        end
    endtask

    // driver model: pops the scoreboard on each accepted word, checks stability while stalling
    task automatic driver();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                data_ack_i = 1'b0;
                idle_i     = 1'b1;
                latch_cnt  = 0;
                held_v     = 1'b0;
                stall_left = stall_cfg;
            end else begin
                data_ack_i = 1'b0;
                if (data_valid_o) begin
                    idle_i = 1'b0;
                    if (stall_left > 0) begin
                        if (held_v) begin
                            checks++;
                            if (data_o !== held_d || data_last_o !== held_l) begin
                                errors++;
                                $display("FAIL stall_hold got %h/%b required %h/%b", data_o, data_last_o, held_d, held_l);
                            end
                        end
                        held_v = 1'b1;
                        held_d = data_o;
                        held_l = data_last_o;
                        stall_left--;
                    end else begin
                        checks++;
                        if (q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_word got %h required none", data_o);
                        end else begin
                            e = q.pop_front();
                            if (data_o !== e.d || data_last_o !== e.l) begin
                                errors++;
                                $display("FAIL word got %h last %b required %h last %b", data_o, data_last_o, e.d, e.l);
                            end
                        end
                        data_ack_i = 1'b1;
                        held_v     = 1'b0;
                        stall_left = stall_cfg;
                        if (data_last_o) latch_cnt = 3;
                    end
                end else begin
                    held_v     = 1'b0;
                    stall_left = stall_cfg;
                    if (latch_cnt > 0) begin
                        latch_cnt--;
                        if (latch_cnt == 0) idle_i = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic write_col(input int idx, input logic [23:0] c);
        @(negedge clk_i);
        col_we_i  = 1'b1;
        col_idx_i = 1'(idx);
        col_i     = c;
        @(negedge clk_i);
        col_we_i  = 1'b0;
        m_col[idx] = c;
    endtask

    task automatic write_bright(input logic [7:0] b);
        @(negedge clk_i);
        bright_we_i = 1'b1;
        bright_i    = b;
        @(negedge clk_i);
        bright_we_i = 1'b0;
        m_bright    = int'(b);
    endtask

    task automatic pulse(input logic u, input logic o);
        @(negedge clk_i);
        update_i = u;
        off_i    = o;
        @(negedge clk_i);
        update_i = 1'b0;
        off_i    = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!data_valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (!data_valid_o) begin
            errors++;
            $display("FAIL %s valid_timeout got 0 required 1", name);
        end
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy_o && n < bound) begin
            @(negedge clk_i);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout busy got %b required 0", name, busy_o);
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s words_missing got %0d required 0", name, q.size());
        end
    endtask

    task automatic check_quiet(input string name);
        checks++;
        if ({busy_o, go_o, data_valid_o, data_last_o, data_o} !== 28'h0) begin
            errors++;
            $display("FAIL %s outputs got busy %b go %b valid %b last %b data %h required all 0",
                     name, busy_o, go_o, data_valid_o, data_last_o, data_o);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        check_quiet("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_quiet("post_reset");
    endtask

    task automatic test_basic();
        write_col(0, 24'hFF0000);
        write_col(1, 24'h00FF00);
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        checks++;
        if (data_valid_o !== 1'b0 || go_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_c1 got valid %b go %b busy %b required 0 1 1", data_valid_o, go_o, busy_o);
        end
        @(negedge clk_i);
        checks++;
        if (data_valid_o !== 1'b1 || data_o !== 24'h00FF00 || data_last_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_c2 got valid %b data %h last %b required 1 00ff00 0", data_valid_o, data_o, data_last_o);
        end
        for (int i = 0; i < 20 && data_valid_o; i++) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || go_o !== 1'b1) begin
            errors++;
            $display("FAIL latch_busy got busy %b go %b required 1 1", busy_o, go_o);
        end
        wait_idle("basic", 50);
        checks++;
        if (go_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_go got %b required 0", go_o);
        end
    endtask

    task automatic test_scale();
        exp_t e;
        write_bright(8'h7F);
        write_col(0, 24'h804020);
        e.d = 24'h204010;
        e.l = 1'b0;
        q.push_back(e);
        e.d = exp_word(m_col[1], m_bright);
        e.l = 1'b1;
        q.push_back(e);
        pulse(1'b1, 1'b0);
        wait_idle("scale", 50);
    endtask

    task automatic test_stall();
        stall_cfg = 50;
        write_col(1, 24'h3C5A96);
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("stall", 400);
        stall_cfg = 0;
    endtask

    task automatic test_off_wins();
        push_frame(1'b1);
        pulse(1'b1, 1'b1);
        wait_idle("off_frame", 50);
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("after_off", 50);
    endtask

    task automatic test_update_during_send();
        stall_cfg = 10;
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_valid("during_send");
        write_col(0, 24'hA0B0C0);
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL pend_busy got %b required 1", busy_o);
        end
        wait_idle("during_send", 600);
        repeat (5) @(negedge clk_i);
        checks++;
        if (go_o !== 1'b0) begin
            errors++;
            $display("FAIL coalesce_go got %b required 0", go_o);
        end
        stall_cfg = 0;
    endtask

    task automatic test_reset_mid();
        stall_cfg = 5;
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_valid("reset_mid");
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check_quiet("reset_async");
        q.delete();
        for (int i = 0; i < N; i++) m_col[i] = 24'h0;
        m_bright = 255;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_quiet("reset_nothing_pending");
        stall_cfg = 0;
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("reset_cols_zero", 50);
        write_col(0, 24'h112233);
        push_frame(1'b0);
        pulse(1'b1, 1'b0);
        wait_idle("reset_bright_ff", 50);
    endtask

    initial begin
        rst_ni      = 1'b0;
        col_we_i    = 1'b0;
        col_idx_i   = '0;
        col_i       = '0;
        bright_we_i = 1'b0;
        bright_i    = '0;
        update_i    = 1'b0;
        off_i       = 1'b0;
        data_ack_i  = 1'b0;
        idle_i      = 1'b1;
        stall_cfg   = 0;
        stall_left  = 0;
        latch_cnt   = 0;
        held_v      = 1'b0;
        held_d      = '0;
        held_l      = 1'b0;
        m_bright    = 255;
        for (int i = 0; i < N; i++) m_col[i] = 24'h0;
        fork
            driver();
        join_none
        test_reset();
        test_basic();
        test_scale();
        test_stall();
        test_off_wins();
        test_update_during_send();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
